confreg_arbiter: RTL and testbench

Two-master arbiter that shares the single conf_en/conf_wen/conf_addr/conf_wdata/conf_rdata port of the configuration-register block (LED/SEG registers at 0xffff0000 / 0xffff0001).
- Master 0 is the CPU data side; master 1 is the debug/loader side.
- Grants are round-robin, one transaction per cycle.
- The owner ID of each issued transaction is tracked through the slave's one-cycle registered read latency, so each response returns to the master that issued it.

---
 rtl/confreg_arbiter.sv | 92 +++++++++
 tb/tb_confreg_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/confreg_arbiter.sv
// confreg_arbiter: round-robin arbiter sharing the confreg slave port between
// two masters, routing each one-cycle-latency response back to its issuer.
module confreg_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int WW = 4
) (
  input  logic          clk,
  input  logic          reset,
  // master 0: CPU data side
  input  logic          m0_req,
  input  logic [WW-1:0] m0_wen,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  // master 1: debug / loader side
  input  logic          m1_req,
  input  logic [WW-1:0] m1_wen,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  // shared slave port
  output logic          conf_en,
  output logic [WW-1:0] conf_wen,
  output logic [AW-1:0] conf_addr,
  output logic [DW-1:0] conf_wdata,
  input  logic [DW-1:0] conf_rdata
);

  logic gnt0_p0;
  logic gnt1_p0;
  logic vld_p0;

  logic rr_last;       // last granted master; 1 after reset so master 0 wins the first tie
  logic vld_p1;        // a response is due this cycle
  logic resp_id_p1;    // owner of that response

  // Stage 0: arbitrate and drive the granted master's fields onto the slave port.
  // On a tie the master that was not granted last wins; nothing is granted in reset.
  always_comb begin
    gnt0_p0    = 1'b0;
    gnt1_p0    = 1'b0;
    conf_wen   = '0;
    conf_addr  = m0_addr;
    conf_wdata = m0_wdata;
    if (!reset) begin
      gnt0_p0 = m0_req & (~m1_req | rr_last);
      gnt1_p0 = m1_req & (~m0_req | ~rr_last);
    end
    vld_p0 = gnt0_p0 | gnt1_p0;
    if (gnt1_p0) begin
      conf_wen   = m1_wen;
      conf_addr  = m1_addr;
      conf_wdata = m1_wdata;
    end else if (gnt0_p0) begin
      conf_wen   = m0_wen;
    end
  end

  assign m0_gnt  = gnt0_p0;
  assign m1_gnt  = gnt1_p0;
  assign conf_en = vld_p0;

  // Stage 0 -> 1: remember who was granted so the response can be steered back.
  // Reset clears a pending response so it is never delivered afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last    <= 1'b1;
      vld_p1     <= 1'b0;
      resp_id_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        rr_last    <= gnt1_p0;
        resp_id_p1 <= gnt1_p0;
      end
    end
  end

  // Stage 1: route the slave's registered read data to the owning master only.
  always_comb begin
    m0_rvalid = vld_p1 & ~resp_id_p1;
    m1_rvalid = vld_p1 &  resp_id_p1;
    m0_rdata  = m0_rvalid ? conf_rdata : '0;
    m1_rdata  = m1_rvalid ? conf_rdata : '0;
  end

endmodule

// File: tb/tb_confreg_arbiter.sv
// Testbench for confreg_arbiter: directed vectors with hand-computed
// expectations queued per master and checked by an independent monitor.
module tb_confreg_arbiter;

  localparam logic [31:0] LED_ADDR = 32'hffff_0000;
  localparam logic [31:0] SEG_ADDR = 32'hffff_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [3:0]  m0_wen, m1_wen;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        conf_en;
  logic [3:0]  conf_wen;
  logic [31:0] conf_addr, conf_wdata;
  logic [31:0] conf_rdata = 32'h0;

  logic [31:0] led = 32'h0;
  logic [31:0] seg = 32'h0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  confreg_arbiter #(.AW(32), .DW(32), .WW(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .conf_en(conf_en), .conf_wen(conf_wen), .conf_addr(conf_addr),
    .conf_wdata(conf_wdata), .conf_rdata(conf_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural confreg slave: byte-write registers, registered read data.
  always @(posedge clk) begin
    if (conf_en) begin
      if (conf_wen == 4'h0) begin
        if (conf_addr == LED_ADDR)      conf_rdata <= led;
        else if (conf_addr == SEG_ADDR) conf_rdata <= seg;
        else                            conf_rdata <= 32'h0;
      end else begin
        conf_rdata <= 32'h0;
        for (int b = 0; b < 4; b++) begin
          if (conf_wen[b]) begin
            if (conf_addr == LED_ADDR) led[8*b +: 8] <= conf_wdata[8*b +: 8];
            if (conf_addr == SEG_ADDR) seg[8*b +: 8] <= conf_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Response monitor for one master: pops the oldest expectation on rvalid.
  task automatic mon(input int id, input logic rv, input logic [31:0] rd);
    exp_t e;
    bit   have;
    have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (id == 0) ? q0[0] : q1[0];
    checks++;
    if (rv === 1'b1) begin
      if (!have) begin
        errors++;
        $display("FAIL m%0d_rvalid_unexpected at cycle %0d: got rvalid=1 expected 0", id, cyc);
      end else begin
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        if (e.due != cyc) begin
          errors++;
          $display("FAIL m%0d_latency: got response at cycle %0d expected cycle %0d", id, cyc, e.due);
        end else if (e.chk && rd !== e.data) begin
          errors++;
          $display("FAIL m%0d_rdata at cycle %0d: got %h expected %h", id, cyc, rd, e.data);
        end
      end
    end else begin
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL m%0d_rdata_idle at cycle %0d: got %h expected 00000000", id, cyc, rd);
      end
      if (have && e.due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL m%0d_rvalid_missing at cycle %0d: got rvalid=%b expected 1", id, cyc, rv);
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, m0_rvalid, m0_rdata);
    mon(1, m1_rvalid, m1_rdata);
  end

  // One cycle of stimulus: drive both masters, check grant/issue mid-cycle,
  // and queue the expected response for the granted master.
  task automatic step(
    input bit r0, input logic [3:0] w0, input logic [31:0] a0, input logic [31:0] d0,
    input bit r1, input logic [3:0] w1, input logic [31:0] a1, input logic [31:0] d1,
    input bit eg0, input bit eg1, input logic [31:0] ed, input bit dchk, input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    m0_req = r0; m0_wen = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_wen = w1; m1_addr = a1; m1_wdata = d1;
    #3;
    chk("m0_gnt", {31'b0, m0_gnt}, {31'b0, eg0});
    chk("m1_gnt", {31'b0, m1_gnt}, {31'b0, eg1});
    chk("conf_en", {31'b0, conf_en}, {31'b0, eg0 | eg1});
    if (eg0 | eg1) begin
      chk("conf_addr", conf_addr, eg1 ? a1 : a0);
      chk("conf_wen", {28'b0, conf_wen}, {28'b0, eg1 ? w1 : w0});
      if (push) begin
        e.due  = cyc + 1;
        e.data = ed;
        e.chk  = dchk;
        if (eg1) q1.push_back(e);
        else     q0.push_back(e);
      end
    end else begin
      chk("conf_wen_idle", {28'b0, conf_wen}, 32'h0);
    end
  endtask

  task automatic idle_check();
    @(posedge clk);
    #4;
    chk("idle_gnt", {30'b0, m0_gnt, m1_gnt}, 32'h0);
    chk("idle_conf_en", {31'b0, conf_en}, 32'h0);
    chk("idle_conf_wen", {28'b0, conf_wen}, 32'h0);
    chk("idle_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'h0);
    chk("idle_noX", {31'b0, $isunknown({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata,
        m1_rdata, conf_en, conf_wen, conf_addr, conf_wdata})}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    // reset held with both masters requesting: nothing may be granted
    reset = 1'b1;
    m0_req = 1'b1; m0_wen = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_wen = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
    @(posedge clk);
    #4;
    chk("rst_gnt", {30'b0, m0_gnt, m1_gnt}, 32'h0);
    chk("rst_conf_en", {31'b0, conf_en}, 32'h0);
    chk("rst_conf_wen", {28'b0, conf_wen}, 32'h0);
    chk("rst_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;

    // idle for 10 cycles
    repeat (10) idle_check();

    // single master: set LED, read it back; m1 loads SEG
    step(1, 4'hF, LED_ADDR, 32'h1234_5678, 0, 4'h0, 0, 0, 1, 0, 32'h0, 0, 1);
    step(1, 4'h0, LED_ADDR, 32'h0,         0, 4'h0, 0, 0, 1, 0, 32'h1234_5678, 1, 1);
    step(0, 4'h0, 0, 0, 1, 4'hF, SEG_ADDR, 32'h0000_BEEF, 0, 1, 32'h0, 0, 1);
    step(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 0);

    // contention straight out of reset: 0,1,0,1
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    step(1, 4'hF, LED_ADDR, 32'hA5A5_A5A5, 1, 4'h0, SEG_ADDR, 0, 1, 0, 32'h0, 0, 1);
    step(1, 4'hF, LED_ADDR, 32'hA5A5_A5A5, 1, 4'h0, SEG_ADDR, 0, 0, 1, 32'h0000_BEEF, 1, 1);
    step(1, 4'hF, LED_ADDR, 32'hA5A5_A5A5, 1, 4'h0, SEG_ADDR, 0, 1, 0, 32'h0, 0, 1);
    step(1, 4'hF, LED_ADDR, 32'hA5A5_A5A5, 1, 4'h0, SEG_ADDR, 0, 0, 1, 32'h0000_BEEF, 1, 1);
    step(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 0);

    // back-to-back reads from m1, including an unmapped address
    step(0, 4'h0, 0, 0, 1, 4'h0, LED_ADDR,     0, 0, 1, 32'hA5A5_A5A5, 1, 1);
    step(0, 4'h0, 0, 0, 1, 4'h0, SEG_ADDR,     0, 0, 1, 32'h0000_BEEF, 1, 1);
    step(0, 4'h0, 0, 0, 1, 4'h0, LED_ADDR,     0, 0, 1, 32'hA5A5_A5A5, 1, 1);
    step(0, 4'h0, 0, 0, 1, 4'h0, 32'h0000_1234, 0, 0, 1, 32'h0, 1, 1);

    // write by m0 then immediate read by m1
    step(1, 4'hF, SEG_ADDR, 32'h0000_0042, 0, 4'h0, 0, 0, 1, 0, 32'h0, 0, 1);
    step(0, 4'h0, 0, 0, 1, 4'h0, SEG_ADDR, 0, 0, 1, 32'h0000_0042, 1, 1);
    step(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 0);

    // reset in the cycle after an m0 grant: its response must vanish
    step(1, 4'h0, LED_ADDR, 0, 0, 4'h0, 0, 0, 1, 0, 32'h0, 0, 0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    m1_req = 1'b1;
    #3;
    chk("rstmid_m0_rvalid", {31'b0, m0_rvalid}, 32'h0);
    chk("rstmid_gnt", {30'b0, m0_gnt, m1_gnt}, 32'h0);
    chk("rstmid_conf_en", {31'b0, conf_en}, 32'h0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    step(1, 4'h0, LED_ADDR, 0, 1, 4'h0, SEG_ADDR, 0, 1, 0, 32'hA5A5_A5A5, 1, 1);
    step(1, 4'h0, LED_ADDR, 0, 1, 4'h0, SEG_ADDR, 0, 0, 1, 32'h0000_0042, 1, 1);
    step(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 0);

    repeat (3) @(posedge clk);
    #4;
    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
